// File: rtl/nic_out_packet_queue_pkg.sv
// NIC output packet queue: shared flit/packet definitions.
// Flit type sits in the top FLIT_TYPE_BITS of every flit.
package nic_out_packet_queue_pkg;

    localparam int FLIT_WIDTH        = 16;
    localparam int MAX_PACKET_LENGHT = 8;
    localparam int PKT_WIDTH         = FLIT_WIDTH * MAX_PACKET_LENGHT;
    localparam int FLIT_TYPE_BITS    = 2;
    localparam int PTR_W             = $clog2(MAX_PACKET_LENGHT);

    typedef logic [FLIT_TYPE_BITS-1:0] flit_type_t;

    localparam flit_type_t BODY_FLIT      = 2'b00;
    localparam flit_type_t HEAD_FLIT      = 2'b01;
    localparam flit_type_t TAIL_FLIT      = 2'b10;
    localparam flit_type_t HEAD_TAIL_FLIT = 2'b11;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        VA_REQUEST   = 2'd1,
        TRANSMISSION = 2'd2,
        RELEASE      = 2'd3
    } state_t;

    function automatic flit_type_t flit_type(input logic [FLIT_WIDTH-1:0] f);
        return f[FLIT_WIDTH-1 -: FLIT_TYPE_BITS];
    endfunction

endpackage

// File: rtl/nic_out_packet_queue_if.sv
// NIC output packet queue: packetiser / router handshake bundle.
// slave = the queue, master = the surrounding NIC and router.
interface nic_out_packet_queue_if
    import nic_out_packet_queue_pkg::*;
#(
    parameter int N_BITS_SLOT    = 2,
    parameter int N_BITS_VNET_ID = 2,
    parameter int N_BITS_VC_ID   = 3
) ();

    logic [PKT_WIDTH-1:0]      pkt_i;
    logic [N_BITS_VNET_ID-1:0] vnet_id_i;
    logic                      is_valid_i;
    logic                      ready_o;
    logic [N_BITS_SLOT:0]      occupancy_o;
    logic                      r_va_o;
    logic [N_BITS_VNET_ID-1:0] vnet_id_o;
    logic                      g_va_i;
    logic [N_BITS_VC_ID-1:0]   vc_id_i;
    logic                      r_la_o;
    logic                      g_la_i;
    logic [FLIT_WIDTH-1:0]     flit_o;
    logic                      is_valid_o;
    logic [N_BITS_VC_ID-1:0]   credit_in_i;
    logic                      release_pointer_o;
    logic [N_BITS_VC_ID-1:0]   vc_id_o;

    modport slave (
        input  pkt_i, vnet_id_i, is_valid_i, g_va_i, vc_id_i,
        input  g_la_i, credit_in_i,
        output ready_o, occupancy_o, r_va_o, vnet_id_o, r_la_o,
        output flit_o, is_valid_o, release_pointer_o, vc_id_o
    );

    modport master (
        output pkt_i, vnet_id_i, is_valid_i, g_va_i, vc_id_i,
        output g_la_i, credit_in_i,
        input  ready_o, occupancy_o, r_va_o, vnet_id_o, r_la_o,
        input  flit_o, is_valid_o, release_pointer_o, vc_id_o
    );

endinterface

// File: rtl/nic_vc_credit_bank.sv
// Per-VC credit counters; credits persist across packets.
// Same-cycle return and consume on one VC cancel out.
module nic_vc_credit_bank #(
    parameter int N_VC          = 3,
    parameter int N_BITS_CREDIT = 4,
    parameter int MAX_CREDIT    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_VC-1:0] vc_sel,
    input  logic            consume,
    input  logic [N_VC-1:0] credit_in,
    output logic            credit_ok
);

    localparam logic [N_BITS_CREDIT-1:0] MAX_C = N_BITS_CREDIT'(MAX_CREDIT);
    localparam logic [N_BITS_CREDIT-1:0] ONE   = N_BITS_CREDIT'(1);

    logic [N_VC-1:0][N_BITS_CREDIT-1:0] cnt_q;

    // consume/return per VC, return saturates at MAX_CREDIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int v = 0; v < N_VC; v++) cnt_q[v] <= MAX_C;
        end else begin
            for (int v = 0; v < N_VC; v++) begin
                if (consume && vc_sel[v] && !credit_in[v])
                    cnt_q[v] <= cnt_q[v] - ONE;
                else if (credit_in[v] && !(consume && vc_sel[v])
                         && cnt_q[v] != MAX_C)
                    cnt_q[v] <= cnt_q[v] + ONE;
            end
        end
    end

    // selected VC still has at least one credit
    always_comb begin
        credit_ok = 1'b0;
        for (int v = 0; v < N_VC; v++)
            if (vc_sel[v] && cnt_q[v] != '0) credit_ok = 1'b1;
    end

endmodule

// File: rtl/nic_out_packet_queue.sv
// NIC output packet queue: N_SLOTS packets, VA then LA per head packet.
// Define NIC_OUTQ_STATS_EN to add flit_count_o / pkt_count_o.
module nic_out_packet_queue
    import nic_out_packet_queue_pkg::*;
#(
    parameter int N_SLOTS              = 4,
    parameter int N_BITS_SLOT          = 2,
    parameter int N_BITS_VNET_ID       = 2,
    parameter int N_BITS_VC_ID         = 3,
    parameter int N_BITS_CREDIT        = 4,
    parameter int MAX_CREDIT           = 4,
    parameter int N_BITS_PACKET_LENGHT = 4
) (
    input  logic clk,
    input  logic rst,
    nic_out_packet_queue_if.slave q
`ifdef NIC_OUTQ_STATS_EN
    ,
    output logic [31:0] flit_count_o,
    output logic [31:0] pkt_count_o
`endif
);

    localparam logic [N_BITS_SLOT:0] FULL =
        (N_BITS_SLOT+1)'(N_SLOTS);
    localparam logic [N_BITS_PACKET_LENGHT-1:0] LAST_FLIT =
        N_BITS_PACKET_LENGHT'(MAX_PACKET_LENGHT-1);

    logic [PKT_WIDTH-1:0]      pkt_mem  [N_SLOTS];
    logic [N_BITS_VNET_ID-1:0] vnet_mem [N_SLOTS];

    logic [N_BITS_SLOT-1:0]          head_q, tail_q;
    logic [N_BITS_SLOT:0]            occ_q, occ_nx;
    state_t                          state_q;
    logic [N_BITS_VC_ID-1:0]         vc_q;
    logic [N_BITS_PACKET_LENGHT-1:0] fptr_q;
    logic [FLIT_WIDTH-1:0]           flit_q, cur_flit;
    logic                            valid_q;
    logic ready, enq, deq, r_la, la_ok, credit_ok, is_tail;
    logic [PTR_W-1:0]                fsel;

    assign ready  = occ_q != FULL;
    assign enq    = q.is_valid_i && ready;
    assign deq    = state_q == RELEASE;
    assign occ_nx = occ_q + {{N_BITS_SLOT{1'b0}}, enq}
                          - {{N_BITS_SLOT{1'b0}}, deq};

    assign fsel     = fptr_q[PTR_W-1:0];
    assign cur_flit = pkt_mem[head_q][int'(fsel)*FLIT_WIDTH +: FLIT_WIDTH];
    assign is_tail  = flit_type(cur_flit) == TAIL_FLIT
                   || flit_type(cur_flit) == HEAD_TAIL_FLIT
                   || fptr_q == LAST_FLIT;

    assign r_la  = state_q == TRANSMISSION && credit_ok;
    assign la_ok = q.g_la_i && r_la;

    assign q.ready_o           = ready;
    assign q.occupancy_o       = occ_q;
    assign q.r_va_o            = state_q == VA_REQUEST;
    assign q.vnet_id_o         = (occ_q != '0) ? vnet_mem[head_q] : '0;
    assign q.r_la_o            = r_la;
    assign q.flit_o            = flit_q;
    assign q.is_valid_o        = valid_q;
    assign q.release_pointer_o = deq;
    assign q.vc_id_o           = deq ? vc_q : '0;

    // packet storage at the tail slot
    always_ff @(posedge clk) begin
        if (enq) begin
            pkt_mem[tail_q]  <= q.pkt_i;
            vnet_mem[tail_q] <= q.vnet_id_i;
        end
    end

    // ring pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (enq) tail_q <= tail_q + N_BITS_SLOT'(1);
            if (deq) head_q <= head_q + N_BITS_SLOT'(1);
            occ_q <= occ_nx;
        end
    end

    // head packet control: VA, flit streaming, release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            vc_q    <= '0;
            fptr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE:
                    if (occ_q != '0) state_q <= VA_REQUEST;
                VA_REQUEST:
                    if (q.g_va_i) begin
                        vc_q    <= q.vc_id_i;
                        fptr_q  <= '0;
                        state_q <= TRANSMISSION;
                    end
                TRANSMISSION:
                    if (la_ok) begin
                        fptr_q <= fptr_q + N_BITS_PACKET_LENGHT'(1);
                        if (is_tail) state_q <= RELEASE;
                    end
                RELEASE:
                    state_q <= (occ_nx != '0) ? VA_REQUEST : IDLE;
                default:
                    state_q <= IDLE;
            endcase
        end
    end

    // granted flit goes on the link one cycle later
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= la_ok;
            if (la_ok) flit_q <= cur_flit;
        end
    end

    nic_vc_credit_bank #(
        .N_VC          (N_BITS_VC_ID),
        .N_BITS_CREDIT (N_BITS_CREDIT),
        .MAX_CREDIT    (MAX_CREDIT)
    ) u_credit (
        .clk       (clk),
        .rst       (rst),
        .vc_sel    (vc_q),
        .consume   (la_ok),
        .credit_in (q.credit_in_i),
        .credit_ok (credit_ok)
    );

`ifdef NIC_OUTQ_STATS_EN
    // link flit and released packet counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_count_o <= '0;
            pkt_count_o  <= '0;
        end else begin
            if (valid_q) flit_count_o <= flit_count_o + 32'd1;
            if (deq)     pkt_count_o  <= pkt_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_nic_out_packet_queue.sv
// Bench for nic_out_packet_queue: directed scenarios plus a random
// run against a packet-level queue/credit model.
module tb_nic_out_packet_queue;
    import nic_out_packet_queue_pkg::*;

    localparam int NS   = 4;
    localparam int MAXC = 4;

    typedef logic [PKT_WIDTH-1:0]  pkt_t;
    typedef logic [FLIT_WIDTH-1:0] flit_t;
    typedef struct {
        pkt_t       p;
        logic [1:0] vnet;
        int         len;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    nic_out_packet_queue_if #(
        .N_BITS_SLOT(2), .N_BITS_VNET_ID(2), .N_BITS_VC_ID(3)
    ) bus ();

`ifdef NIC_OUTQ_STATS_EN
    logic [31:0] flit_count, pkt_count;
`endif

    nic_out_packet_queue #(
        .N_SLOTS(NS), .N_BITS_SLOT(2), .N_BITS_VNET_ID(2),
        .N_BITS_VC_ID(3), .N_BITS_CREDIT(4), .MAX_CREDIT(MAXC),
        .N_BITS_PACKET_LENGHT(4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
`ifdef NIC_OUTQ_STATS_EN
        ,
        .flit_count_o (flit_count),
        .pkt_count_o  (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic pkt_t make_pkt(input int len);
        pkt_t       p;
        flit_type_t t;
        p = '0;
        for (int k = 0; k < len; k++) begin
            if (len == 1)          t = HEAD_TAIL_FLIT;
            else if (k == 0)       t = HEAD_FLIT;
            else if (k == len - 1) t = TAIL_FLIT;
            else                   t = BODY_FLIT;
            p[k*FLIT_WIDTH +: FLIT_WIDTH] =
                {t, (FLIT_WIDTH-FLIT_TYPE_BITS)'($urandom)};
        end
        return p;
    endfunction

    function automatic flit_t flit_at(input pkt_t p, input int k);
        return p[k*FLIT_WIDTH +: FLIT_WIDTH];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.pkt_i       = '0;
        bus.vnet_id_i   = '0;
        bus.is_valid_i  = 1'b0;
        bus.g_va_i      = 1'b0;
        bus.vc_id_i     = '0;
        bus.g_la_i      = 1'b0;
        bus.credit_in_i = '0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        idle_inputs();
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic enqueue(input pkt_t p, input logic [1:0] vn);
        bus.pkt_i      = p;
        bus.vnet_id_i  = vn;
        bus.is_valid_i = 1'b1;
        tick();
        bus.is_valid_i = 1'b0;
    endtask

    task automatic wait_va(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.r_va_o) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_total++; if (bus.ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready_o); else n_pass++;
        n_total++; if (bus.occupancy_o !== 3'd0) $display("FAIL reset_occ: got %0d want 0", bus.occupancy_o); else n_pass++;
        n_total++; if (bus.r_va_o !== 1'b0) $display("FAIL reset_r_va: got %b want 0", bus.r_va_o); else n_pass++;
        n_total++; if (bus.r_la_o !== 1'b0) $display("FAIL reset_r_la: got %b want 0", bus.r_la_o); else n_pass++;
        n_total++; if (bus.is_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.is_valid_o); else n_pass++;
        n_total++; if (bus.release_pointer_o !== 1'b0) $display("FAIL reset_release: got %b want 0", bus.release_pointer_o); else n_pass++;
        n_total++; if (bus.vc_id_o !== 3'd0) $display("FAIL reset_vc_id: got %b want 000", bus.vc_id_o); else n_pass++;
        n_total++; if (bus.flit_o !== '0) $display("FAIL reset_flit: got %h want 0", bus.flit_o); else n_pass++;
        for (int v = 0; v < 3; v++) begin
            n_total++; if (dut.u_credit.cnt_q[v] !== 4'(MAXC)) $display("FAIL reset_credit%0d: got %0d want %0d", v, dut.u_credit.cnt_q[v], MAXC); else n_pass++;
        end
    endtask

    task automatic test_basic;
        pkt_t p;
        bit   ok;
        do_reset();
        p = make_pkt(3);
        enqueue(p, 2'd1);
        n_total++; if (bus.occupancy_o !== 3'd1) $display("FAIL basic_occ: got %0d want 1", bus.occupancy_o); else n_pass++;
        wait_va(ok);
        n_total++; if (!ok) $display("FAIL basic_va_timeout: got no r_va_o want r_va_o=1"); else n_pass++;
        n_total++; if (bus.vnet_id_o !== 2'd1) $display("FAIL basic_vnet: got %0d want 1", bus.vnet_id_o); else n_pass++;
        bus.g_va_i  = 1'b1;
        bus.vc_id_i = 3'b010;
        tick();
        bus.g_va_i = 1'b0;
        n_total++; if (bus.r_va_o !== 1'b0) $display("FAIL basic_va_len: got %b want 0", bus.r_va_o); else n_pass++;
        n_total++; if (bus.r_la_o !== 1'b1) $display("FAIL basic_r_la: got %b want 1", bus.r_la_o); else n_pass++;
        bus.g_la_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++; if (bus.is_valid_o !== 1'b1 || bus.flit_o !== flit_at(p, k)) $display("FAIL basic_flit%0d: got %b/%h want 1/%h", k, bus.is_valid_o, bus.flit_o, flit_at(p, k)); else n_pass++;
        end
        n_total++; if (bus.release_pointer_o !== 1'b1) $display("FAIL basic_release: got %b want 1", bus.release_pointer_o); else n_pass++;
        n_total++; if (bus.vc_id_o !== 3'b010) $display("FAIL basic_vc_id: got %b want 010", bus.vc_id_o); else n_pass++;
        n_total++; if (bus.r_la_o !== 1'b0) $display("FAIL basic_r_la_rel: got %b want 0", bus.r_la_o); else n_pass++;
        bus.g_la_i = 1'b0;
        tick();
        n_total++; if (bus.release_pointer_o !== 1'b0) $display("FAIL basic_release_len: got %b want 0", bus.release_pointer_o); else n_pass++;
        n_total++; if (bus.occupancy_o !== 3'd0) $display("FAIL basic_occ_end: got %0d want 0", bus.occupancy_o); else n_pass++;
        n_total++; if (dut.u_credit.cnt_q[1] !== 4'd1) $display("FAIL basic_credit: got %0d want 1", dut.u_credit.cnt_q[1]); else n_pass++;
    endtask

    task automatic test_credit_stall;
        pkt_t  p;
        bit    ok, rel;
        int    ngr;
        flit_t got[$];
        do_reset();
        p = make_pkt(6);
        enqueue(p, 2'd0);
        wait_va(ok);
        n_total++; if (!ok) $display("FAIL stall_va_timeout: got no r_va_o want r_va_o=1"); else n_pass++;
        bus.g_va_i  = 1'b1;
        bus.vc_id_i = 3'b010;
        tick();
        bus.g_va_i = 1'b0;
        bus.g_la_i = 1'b1;
        ngr = 0;
        for (int i = 0; i < 20; i++) begin
            if (!bus.r_la_o) break;
            tick();
            ngr++;
            if (bus.is_valid_o) got.push_back(bus.flit_o);
        end
        n_total++; if (ngr !== 4) $display("FAIL stall_grants: got %0d want 4", ngr); else n_pass++;
        tick();
        n_total++; if (bus.r_la_o !== 1'b0 || bus.is_valid_o !== 1'b0) $display("FAIL stall_hold: got r_la=%b valid=%b want 0/0", bus.r_la_o, bus.is_valid_o); else n_pass++;
        bus.credit_in_i = 3'b010;
        tick();
        n_total++; if (bus.r_la_o !== 1'b1) $display("FAIL stall_resume: got %b want 1", bus.r_la_o); else n_pass++;
        rel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.is_valid_o) got.push_back(bus.flit_o);
            if (bus.release_pointer_o) begin
                rel = 1'b1;
                break;
            end
        end
        bus.credit_in_i = '0;
        bus.g_la_i      = 1'b0;
        n_total++; if (!rel) $display("FAIL stall_release: got no release want release"); else n_pass++;
        n_total++; if (got.size() !== 6) $display("FAIL stall_nflits: got %0d want 6", got.size()); else n_pass++;
        for (int k = 0; k < 6 && k < got.size(); k++) begin
            n_total++; if (got[k] !== flit_at(p, k)) $display("FAIL stall_flit%0d: got %h want %h", k, got[k], flit_at(p, k)); else n_pass++;
        end
        tick();
        n_total++; if (dut.u_credit.cnt_q[1] !== 4'd1) $display("FAIL stall_credit: got %0d want 1", dut.u_credit.cnt_q[1]); else n_pass++;
    endtask

    task automatic test_full;
        pkt_t  pk[5];
        int    ln[5];
        int    nrel;
        flit_t exp[$];
        flit_t got[$];
        do_reset();
        for (int k = 0; k < 5; k++) begin
            ln[k] = $urandom_range(1, 4);
            pk[k] = make_pkt(ln[k]);
        end
        for (int k = 0; k < 4; k++) begin
            for (int f = 0; f < ln[k]; f++) exp.push_back(flit_at(pk[k], f));
            bus.pkt_i      = pk[k];
            bus.vnet_id_i  = 2'(k);
            bus.is_valid_i = 1'b1;
            tick();
        end
        bus.is_valid_i = 1'b0;
        n_total++; if (bus.occupancy_o !== 3'd4) $display("FAIL full_occ: got %0d want 4", bus.occupancy_o); else n_pass++;
        n_total++; if (bus.ready_o !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.ready_o); else n_pass++;
        enqueue(pk[4], 2'd3);
        n_total++; if (bus.occupancy_o !== 3'd4) $display("FAIL full_ignore: got %0d want 4", bus.occupancy_o); else n_pass++;
        bus.g_la_i      = 1'b1;
        bus.credit_in_i = 3'b111;
        bus.vc_id_i     = 3'b001;
        nrel = 0;
        for (int i = 0; i < 200 && nrel < 4; i++) begin
            bus.g_va_i = bus.r_va_o;
            tick();
            if (bus.is_valid_o) got.push_back(bus.flit_o);
            if (bus.release_pointer_o) begin
                n_total++; if (bus.occupancy_o !== 3'(4 - nrel)) $display("FAIL full_occ_step%0d: got %0d want %0d", nrel, bus.occupancy_o, 4 - nrel); else n_pass++;
                nrel++;
            end
        end
        idle_inputs();
        tick();
        n_total++; if (nrel !== 4) $display("FAIL full_releases: got %0d want 4", nrel); else n_pass++;
        n_total++; if (bus.occupancy_o !== 3'd0) $display("FAIL full_occ_end: got %0d want 0", bus.occupancy_o); else n_pass++;
        n_total++; if (got.size() !== exp.size()) $display("FAIL full_nflits: got %0d want %0d", got.size(), exp.size()); else n_pass++;
        for (int k = 0; k < exp.size() && k < got.size(); k++) begin
            n_total++; if (got[k] !== exp[k]) $display("FAIL full_order%0d: got %h want %h", k, got[k], exp[k]); else n_pass++;
        end
    endtask

    task automatic test_credit_sim;
        pkt_t p;
        bit   ok;
        do_reset();
        p = make_pkt(3);
        enqueue(p, 2'd3);
        wait_va(ok);
        n_total++; if (!ok) $display("FAIL sim_va_timeout: got no r_va_o want r_va_o=1"); else n_pass++;
        bus.g_va_i  = 1'b1;
        bus.vc_id_i = 3'b100;
        tick();
        bus.g_va_i = 1'b0;
        bus.g_la_i = 1'b1;
        tick();
        n_total++; if (dut.u_credit.cnt_q[2] !== 4'd3) $display("FAIL sim_dec: got %0d want 3", dut.u_credit.cnt_q[2]); else n_pass++;
        bus.credit_in_i = 3'b100;
        tick();
        n_total++; if (dut.u_credit.cnt_q[2] !== 4'd3) $display("FAIL sim_both: got %0d want 3", dut.u_credit.cnt_q[2]); else n_pass++;
        bus.credit_in_i = '0;
        tick();
        n_total++; if (dut.u_credit.cnt_q[2] !== 4'd2 || bus.release_pointer_o !== 1'b1) $display("FAIL sim_tail: got %0d/%b want 2/1", dut.u_credit.cnt_q[2], bus.release_pointer_o); else n_pass++;
        bus.g_la_i      = 1'b0;
        bus.credit_in_i = 3'b100;
        tick();
        n_total++; if (dut.u_credit.cnt_q[2] !== 4'd3) $display("FAIL sim_inc: got %0d want 3", dut.u_credit.cnt_q[2]); else n_pass++;
        tick();
        n_total++; if (dut.u_credit.cnt_q[2] !== 4'd4) $display("FAIL sim_inc_max: got %0d want 4", dut.u_credit.cnt_q[2]); else n_pass++;
        bus.credit_in_i = 3'b101;
        tick();
        bus.credit_in_i = '0;
        n_total++; if (dut.u_credit.cnt_q[2] !== 4'd4) $display("FAIL sim_sat2: got %0d want 4", dut.u_credit.cnt_q[2]); else n_pass++;
        n_total++; if (dut.u_credit.cnt_q[0] !== 4'd4) $display("FAIL sim_sat0: got %0d want 4", dut.u_credit.cnt_q[0]); else n_pass++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int nrel;
        do_reset();
        enqueue(make_pkt(6), 2'd2);
        enqueue(make_pkt(2), 2'd1);
        wait_va(ok);
        n_total++; if (!ok) $display("FAIL rmid_va_timeout: got no r_va_o want r_va_o=1"); else n_pass++;
        bus.g_va_i  = 1'b1;
        bus.vc_id_i = 3'b001;
        tick();
        bus.g_va_i = 1'b0;
        bus.g_la_i = 1'b1;
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        n_total++; if (bus.r_la_o !== 1'b0 || bus.r_va_o !== 1'b0) $display("FAIL rmid_req: got la=%b va=%b want 0/0", bus.r_la_o, bus.r_va_o); else n_pass++;
        n_total++; if (bus.is_valid_o !== 1'b0 || bus.flit_o !== '0) $display("FAIL rmid_link: got %b/%h want 0/0", bus.is_valid_o, bus.flit_o); else n_pass++;
        n_total++; if (bus.occupancy_o !== 3'd0 || bus.ready_o !== 1'b1) $display("FAIL rmid_occ: got %0d/%b want 0/1", bus.occupancy_o, bus.ready_o); else n_pass++;
        for (int v = 0; v < 3; v++) begin
            n_total++; if (dut.u_credit.cnt_q[v] !== 4'd4) $display("FAIL rmid_credit%0d: got %0d want 4", v, dut.u_credit.cnt_q[v]); else n_pass++;
        end
        nrel = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst = 1'b1;
            tick();
            if (bus.release_pointer_o || bus.is_valid_o || bus.r_va_o) nrel++;
        end
        bus.g_la_i = 1'b0;
        n_total++; if (nrel !== 0) $display("FAIL rmid_quiet: got %0d active cycles want 0", nrel); else n_pass++;
    endtask

    task automatic test_random;
        ent_t       mq[$];
        ent_t       e;
        int         cred_m[3];
        bit         active, exp_valid, exp_rel, exp_rla, acc_la, acc_va;
        bit         nx_valid, nx_rel, do_enq, inc, dec;
        int         remaining, sent_idx, gen, released, cidx;
        logic [2:0] act_vc, vc_pick, ci;
        flit_t      exp_flit;
        do_reset();
        for (int v = 0; v < 3; v++) cred_m[v] = MAXC;
        active = 0; exp_valid = 0; exp_rel = 0;
        remaining = 0; sent_idx = 0; gen = 0; released = 0;
        act_vc = 3'b001; exp_flit = '0;
        for (int cyc = 0; cyc < 6000 && released < 40; cyc++) begin
            cidx = act_vc[2] ? 2 : (act_vc[1] ? 1 : 0);
            exp_rla = active && remaining > 0 && cred_m[cidx] > 0;
            n_total++; if (bus.occupancy_o !== 3'(mq.size())) $display("FAIL rnd_occ c%0d: got %0d want %0d", cyc, bus.occupancy_o, mq.size()); else n_pass++;
            n_total++; if (bus.ready_o !== (mq.size() < NS)) $display("FAIL rnd_ready c%0d: got %b want %b", cyc, bus.ready_o, mq.size() < NS); else n_pass++;
            n_total++; if (bus.is_valid_o !== exp_valid) $display("FAIL rnd_valid c%0d: got %b want %b", cyc, bus.is_valid_o, exp_valid); else n_pass++;
            if (exp_valid) begin
                n_total++; if (bus.flit_o !== exp_flit) $display("FAIL rnd_flit c%0d: got %h want %h", cyc, bus.flit_o, exp_flit); else n_pass++;
            end
            n_total++; if (bus.release_pointer_o !== exp_rel) $display("FAIL rnd_release c%0d: got %b want %b", cyc, bus.release_pointer_o, exp_rel); else n_pass++;
            if (exp_rel) begin
                n_total++; if (bus.vc_id_o !== act_vc) $display("FAIL rnd_vc_id c%0d: got %b want %b", cyc, bus.vc_id_o, act_vc); else n_pass++;
            end
            n_total++; if (bus.r_la_o !== exp_rla) $display("FAIL rnd_r_la c%0d: got %b want %b", cyc, bus.r_la_o, exp_rla); else n_pass++;
            n_total++; if (bus.r_va_o && (active || exp_rel || mq.size() == 0)) $display("FAIL rnd_r_va c%0d: got 1 want 0", cyc); else n_pass++;
            if (bus.r_va_o && mq.size() > 0) begin
                n_total++; if (bus.vnet_id_o !== mq[0].vnet) $display("FAIL rnd_vnet c%0d: got %0d want %0d", cyc, bus.vnet_id_o, mq[0].vnet); else n_pass++;
            end
            for (int v = 0; v < 3; v++) begin
                n_total++; if (dut.u_credit.cnt_q[v] !== 4'(cred_m[v])) $display("FAIL rnd_credit%0d c%0d: got %0d want %0d", v, cyc, dut.u_credit.cnt_q[v], cred_m[v]); else n_pass++;
            end
            do_enq = gen < 40 && $urandom_range(2) == 0;
            e.len  = $urandom_range(1, MAX_PACKET_LENGHT);
            e.p    = make_pkt(e.len);
            e.vnet = 2'($urandom_range(3));
            bus.pkt_i      = e.p;
            bus.vnet_id_i  = e.vnet;
            bus.is_valid_i = do_enq;
            vc_pick        = 3'b001 << $urandom_range(2);
            bus.vc_id_i    = vc_pick;
            bus.g_va_i     = bus.r_va_o ? 1'($urandom_range(1)) : ($urandom_range(7) == 0);
            bus.g_la_i     = $urandom_range(3) != 0;
            for (int v = 0; v < 3; v++) ci[v] = $urandom_range(3) == 0;
            bus.credit_in_i = ci;
            acc_va = bus.r_va_o && bus.g_va_i && !active && !exp_rel && mq.size() > 0;
            acc_la = bus.g_la_i && exp_rla;
            nx_valid = acc_la;
            nx_rel   = 1'b0;
            if (acc_la) begin
                exp_flit = flit_at(mq[0].p, sent_idx);
                sent_idx++;
                remaining--;
                nx_rel = remaining == 0;
            end
            for (int v = 0; v < 3; v++) begin
                inc = ci[v];
                dec = acc_la && act_vc[v];
                if (dec && !inc) cred_m[v]--;
                else if (inc && !dec && cred_m[v] < MAXC) cred_m[v]++;
            end
            if (do_enq && mq.size() < NS) begin
                mq.push_back(e);
                gen++;
            end
            if (exp_rel) begin
                void'(mq.pop_front());
                active = 1'b0;
                released++;
            end
            if (acc_va) begin
                active    = 1'b1;
                act_vc    = vc_pick;
                remaining = mq[0].len;
                sent_idx  = 0;
            end
            exp_valid = nx_valid;
            exp_rel   = nx_rel;
            tick();
        end
        idle_inputs();
        n_total++; if (released !== 40) $display("FAIL rnd_drain: got %0d packets want 40", released); else n_pass++;
    endtask

`ifdef NIC_OUTQ_STATS_EN
    task automatic test_stats;
        int nrel;
        do_reset();
        enqueue(make_pkt(2), 2'd0);
        enqueue(make_pkt(3), 2'd1);
        bus.g_la_i      = 1'b1;
        bus.credit_in_i = 3'b001;
        bus.vc_id_i     = 3'b001;
        nrel = 0;
        for (int i = 0; i < 100 && nrel < 2; i++) begin
            bus.g_va_i = bus.r_va_o;
            tick();
            if (bus.release_pointer_o) nrel++;
        end
        idle_inputs();
        tick();
        n_total++; if (flit_count !== 32'd5) $display("FAIL stats_flits: got %0d want 5", flit_count); else n_pass++;
        n_total++; if (pkt_count !== 32'd2) $display("FAIL stats_pkts: got %0d want 2", pkt_count); else n_pass++;
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_basic();
        test_credit_stall();
        test_full();
        test_credit_sim();
        test_reset_mid();
        test_random();
`ifdef NIC_OUTQ_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
